// File: rtl/math_op_pkg.sv
// Shared constants for the math_op_pipe block.
// Holds default parameter values and the derived stage widths.
// The width helpers take the operand width, so parameterised instances
// can size their datapath the same way the defaults are sized here.
package math_op_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OFFSET = 3;
  localparam int DEF_CNT_W  = 16;

  function automatic int sq_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int sum_w(input int dw);
    return dw + 1;
  endfunction

  function automatic int prod_w(input int dw);
    return 3 * dw + 1;
  endfunction

  function automatic int res_w(input int dw);
    return 3 * dw + 2;
  endfunction

  localparam int SQ_W   = sq_w(DEF_DATA_W);
  localparam int SUM_W  = sum_w(DEF_DATA_W);
  localparam int PROD_W = prod_w(DEF_DATA_W);
  localparam int RES_W  = res_w(DEF_DATA_W);

endpackage

// File: rtl/math_op_sat.sv
// Combinational reduction of the full-precision result to DATA_W bits.
// Ports:
//   res : RES_W-bit signed exact result (prod + OFFSET)
//   d   : DATA_W-bit signed reduced result
//   ovf : 1 when res lies outside the signed DATA_W range
// Macro MATH_OP_SAT_EN: when defined, out-of-range results clamp to the
// signed max/min; otherwise d is the two's-complement wrap (low bits).
module math_op_sat
  import math_op_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [res_w(DATA_W)-1:0] res,
  output logic signed [DATA_W-1:0]        d,
  output logic                            ovf
);

  localparam int RB = res_w(DATA_W);
  localparam int HB = RB - DATA_W + 1;

  // The value fits iff every bit from the DATA_W sign bit upward is a copy
  // of the sign bit.
  logic [HB-1:0] head;
  assign head = res[RB-1:DATA_W-1];
  assign ovf  = !((&head) || !(|head));

`ifdef MATH_OP_SAT_EN
  always_comb begin
    d = res[DATA_W-1:0];
    if (ovf) begin
      d = res[RB-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign d = res[DATA_W-1:0];
`endif

endmodule

// File: rtl/math_op_pipe.sv
// Three-stage pipeline computing d = OFFSET + c*c*(a+b) with exact signed
// arithmetic, a valid/ready handshake and a saturating overflow counter.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   a, b, c, in_valid    : signed operands and their valid strobe
//   in_ready             : operands accepted this cycle (global advance enable)
//   d, out_valid         : signed result and its valid flag
//   out_ready            : downstream accepts d
//   out_ovf              : exact result of the beat on d did not fit DATA_W
//   ovf_cnt              : delivered beats with out_ovf set (saturating)
// Macro MATH_OP_SAT_EN (handled in math_op_sat): clamp instead of wrap.
module math_op_pipe
  import math_op_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFFSET = DEF_OFFSET,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_ovf,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int SQ_BITS   = sq_w(DATA_W);
  localparam int SUM_BITS  = sum_w(DATA_W);
  localparam int PROD_BITS = prod_w(DATA_W);
  localparam int RES_BITS  = res_w(DATA_W);

  localparam logic signed [RES_BITS-1:0] OFF_EXT = RES_BITS'(OFFSET);

  logic en;
  logic v1, v2;

  logic signed [SQ_BITS-1:0]   c_ext, sq;
  logic signed [SUM_BITS-1:0]  sum;
  logic signed [PROD_BITS-1:0] sq_ext, sum_ext, prod;
  logic signed [RES_BITS-1:0]  res;
  logic signed [DATA_W-1:0]    d_next;
  logic                        ovf_next;

  // Single advance enable: every stage, including bubbles, moves together.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Explicit sign extension so the products are exact at full width.
  assign c_ext   = {{DATA_W{c[DATA_W-1]}}, c};
  assign sq_ext  = {{(DATA_W+1){sq[SQ_BITS-1]}}, sq};
  assign sum_ext = {{(2*DATA_W){sum[SUM_BITS-1]}}, sum};
  assign res     = {prod[PROD_BITS-1], prod} + OFF_EXT;

  math_op_sat #(
    .DATA_W(DATA_W)
  ) u_sat (
    .res(res),
    .d  (d_next),
    .ovf(ovf_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      d         <= '0;
      sq        <= '0;
      sum       <= '0;
      prod      <= '0;
    end else if (en) begin
      v1        <= in_valid;
      sq        <= c_ext * c_ext;
      sum       <= {a[DATA_W-1], a} + {b[DATA_W-1], b};
      v2        <= v1;
      prod      <= sq_ext * sum_ext;
      out_valid <= v2;
      d         <= d_next;
      out_ovf   <= ovf_next && v2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_math_op_pipe.sv
// Self-checking bench for math_op_pipe: directed scenarios plus randomized
// traffic checked against a wide-integer reference model and a FIFO
// scoreboard. A second instance with a 2-bit counter exercises saturation.
module tb_math_op_pipe;

  localparam int DW  = 32;
  localparam int OFF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [DW-1:0] a, b, c, d;
  logic                 in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0]          ovf_cnt;

  logic signed [DW-1:0] a2, b2, c2, d2;
  logic                 in_valid2, in_ready2, out_valid2, out_ovf2;
  logic [1:0]           ovf_cnt2;

  math_op_pipe dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .in_valid(in_valid),
    .in_ready(in_ready), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .ovf_cnt(ovf_cnt)
  );

  math_op_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .c(c2), .in_valid(in_valid2),
    .in_ready(in_ready2), .d(d2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_ovf(out_ovf2), .ovf_cnt(ovf_cnt2)
  );

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 ovf;
    int unsigned          cyc;
  } exp_t;

  exp_t        q[$];
  int          compared = 0;
  int          mismatched = 0;
  int unsigned cyc = 0;
  int          ref_cnt = 0;
  bit          chk_lat = 0;
  logic signed [DW-1:0] held;

  function automatic exp_t model(input logic signed [DW-1:0] x, y, z);
    exp_t r;
    logic signed [127:0] e, hi, lo;
    e  = 128'(OFF) + 128'(z) * 128'(z) * (128'(x) + 128'(y));
    hi = (128'sd1 <<< (DW-1)) - 128'sd1;
    lo = -(128'sd1 <<< (DW-1));
    r.ovf = (e > hi) || (e < lo);
`ifdef MATH_OP_SAT_EN
    if (e > hi)      r.d = hi[DW-1:0];
    else if (e < lo) r.d = lo[DW-1:0];
    else             r.d = e[DW-1:0];
`else
    r.d = e[DW-1:0];
`endif
    r.cyc = 0;
    return r;
  endfunction

  function automatic logic signed [DW-1:0] rnd();
    logic signed [DW-1:0] v;
    v = $urandom();
    if ($urandom_range(3, 0) != 0) v = v >>> $urandom_range(31, 0);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e = model(a, b, c);
      e.cyc = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      chk("beat_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("d", d, e.d);
        chk("out_ovf", out_ovf, e.ovf);
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd3);
        if (e.ovf && ref_cnt < 65535) ref_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("ovf_cnt", ovf_cnt, 64'(ref_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ref_cnt = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_d", d, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 1; a = 0; b = 0; c = 0;
    in_valid2 = 0; a2 = 0; b2 = 0; c2 = 0;
    @(negedge clk);
    do_reset();

    // Single beat: latency and value.
    chk_lat = 1;
    a = 1; b = 2; c = 4; in_valid = 1;
    step();
    in_valid = 0;
    step();
    chk("r034_early", out_valid, 0);
    step();
    chk("r034_valid", out_valid, 1);
    chk("r034_d", d, 51);
    chk("r034_ovf", out_ovf, 0);
    step();

    // Back-to-back beats.
    a = -5; b = 2; c = 3; in_valid = 1;
    step();
    a = 0; b = 0; c = 7;
    step();
    in_valid = 0;
    step();
    chk("r035_d0", d, -24);
    step();
    chk("r035_valid1", out_valid, 1);
    chk("r035_d1", d, 3);
    step();

    // Overflow case.
    a = 32'sh4000_0000; b = 32'sh4000_0000; c = 32'sh0001_0000; in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    chk("r036_ovf", out_ovf, 1);
`ifdef MATH_OP_SAT_EN
    chk("r036_d", d, 64'h7fff_ffff);
`else
    chk("r036_d", d, 3);
`endif
    step();
    chk("r036_cnt", ovf_cnt, 1);
    chk_lat = 0;

    // Backpressure with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      a = rnd(); b = rnd(); c = rnd(); in_valid = 1;
      step();
    end
    out_ready = 0;
    a = rnd(); b = rnd(); c = rnd();
    #1;
    held = d;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_d", d, held);
      step();
    end
    out_ready = 1; in_valid = 0;
    repeat (5) step();
    chk("r037_drained", 64'(q.size()), 0);

    // Reset with two beats in flight.
    a = 32'sh4000_0000; b = 32'sh4000_0000; c = 32'sh0001_0000; in_valid = 1;
    step();
    step();
    in_valid = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("r038_no_valid", out_valid, 0);
      step();
    end
    chk("r038_cnt", ovf_cnt, 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      a = rnd(); b = rnd(); c = rnd();
      in_valid  = ($urandom_range(9, 0) < 7);
      out_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (6) step();
    chk("rand_drained", 64'(q.size()), 0);

    // Counter saturation on the narrow-counter instance.
    a2 = 32'sh4000_0000; b2 = 32'sh4000_0000; c2 = 32'sh0001_0000; in_valid2 = 1;
    repeat (5) step();
    chk("r039_mid", ovf_cnt2, 2);
    in_valid2 = 0;
    repeat (5) step();
    chk("r039_sat", ovf_cnt2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/math_op_pipe.md
MATH_OP_PIPE -- requirements
Module: math_op_pipe

Interface
REQ-001 Parameter DATA_W, default 32: signed operand and result width, legal range 8..32.
REQ-002 Parameter OFFSET, default 3: signed additive constant, representable in DATA_W bits.
REQ-003 Parameter CNT_W, default 16: width of the overflow event counter.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Ports a, b, c, input, DATA_W each: signed operands.
REQ-007 Port in_valid, input, 1: operands valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts operands this cycle.
REQ-009 Port d, output, DATA_W: signed result.
REQ-010 Port out_valid, output, 1: d is valid.
REQ-011 Port out_ready, input, 1: downstream accepts d.
REQ-012 Port out_ovf, output, 1: the exact result of the beat on d did not fit DATA_W bits signed.
REQ-013 Port ovf_cnt, output, CNT_W: count of delivered beats with out_ovf=1.

Function
REQ-014 The block SHALL compute d = OFFSET + c*c*(a+b) using exact signed arithmetic before the final width reduction.
REQ-015 Stage 1 SHALL register sq = c*c at 2*DATA_W bits and sum = a+b at DATA_W+1 bits.
REQ-016 Stage 2 SHALL register prod = sq*sum at 3*DATA_W+1 bits.
REQ-017 Stage 3 SHALL register the reduced result of prod+OFFSET (3*DATA_W+2 bits), together with out_ovf and out_valid.
REQ-018 Each stage SHALL carry a valid bit; the global advance enable SHALL be en = !out_valid || out_ready.
REQ-019 in_ready SHALL equal en; an input is accepted iff in_valid && in_ready.
REQ-020 With out_ready held at 1, latency from acceptance to out_valid SHALL be exactly 3 cycles, at a throughput of 1 beat per cycle.
REQ-021 When en=0, all stage registers, d, out_ovf and out_valid SHALL hold their values.
REQ-022 Empty (bubble) stages SHALL advance only under en; bubbles are not collapsed.
REQ-023 A beat is delivered iff out_valid && out_ready.
REQ-024 On each delivered beat with out_ovf=1, ovf_cnt SHALL increment and saturate at 2^CNT_W-1.
REQ-025 out_ovf SHALL be 1 iff prod+OFFSET lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].

Reset
REQ-026 When rst=1 at a clock edge, all stage valid bits, out_valid, out_ovf, d and ovf_cnt SHALL become 0.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight beats without delivering them.
REQ-028 in_ready SHALL be 1 in the cycle after reset (out_valid=0).

Configuration
REQ-029 With macro MATH_OP_SAT_EN defined, an out-of-range result SHALL clamp to the signed DATA_W maximum or minimum.
REQ-030 Without MATH_OP_SAT_EN, d SHALL be the low DATA_W bits of prod+OFFSET (two's-complement wrap).
REQ-031 out_ovf and ovf_cnt SHALL behave identically in both builds.

Structure
REQ-032 Package math_op_pkg SHALL hold the default DATA_W, OFFSET and CNT_W, plus derived width constants SQ_W, SUM_W, PROD_W and RES_W.
REQ-033 Sub-module math_op_sat SHALL perform the combinational RES_W-to-DATA_W reduction and overflow detection; it contains the MATH_OP_SAT_EN branch.

Verification
REQ-034 Reset, then a=1, b=2, c=4, out_ready=1 -> d=51, out_ovf=0, out_valid exactly 3 cycles after acceptance.
REQ-035 Back-to-back inputs a=-5, b=2, c=3 then a=0, b=0, c=7 -> d=-24 then d=3 on consecutive cycles.
REQ-036 DATA_W=32, a=b=2^30, c=2^16 -> out_ovf=1, ovf_cnt=1; d=2^31-1 with MATH_OP_SAT_EN, otherwise d=3.
REQ-037 out_ready=0 for 5 cycles with 3 beats in flight -> in_ready=0, d held stable; on release, beats are delivered in order with none lost or duplicated.
REQ-038 Assert rst for 1 cycle with 2 beats in flight -> out_valid stays 0 afterwards and ovf_cnt=0.
REQ-039 CNT_W=2, 5 overflowing beats -> ovf_cnt saturates at 3.
